// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the miniRV load/store unit.
// Holds the op encoding, FSM state constants and size/alignment helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    LB,
    LH,
    LW,
    LBU,
    LHU,
    SB,
    SH,
    SW
  } lsu_op_t;

  typedef logic [1:0] lsu_state_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic is_store(lsu_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic [1:0] op_size(lsu_op_t op);
    logic [1:0] sz;
    unique case (op)
      LB, LBU, SB: sz = SZ_B;
      LH, LHU, SH: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(
    lsu_op_t    op,
    logic [1:0] off
  );
    logic bad;
    unique case (op_size(op))
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: data-memory valid/ready bus between the LSU and memory.
// master = LSU side (drives request), slave = memory side.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req_valid,
    input  mem_req_ready,
    output mem_addr,
    output mem_wen,
    output mem_wdata,
    output mem_wstrb,
    input  mem_resp_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_addr,
    input  mem_wen,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_resp_valid,
    output mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the LSU.
// Ports: op/off/wdata/rdata in; wdata_lane, wstrb, rdata_ext out.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_lane,
  output logic [3:0]  wstrb,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lb;
  logic [15:0] lh;

  // half select uses off[1] only: misaligned halves truncate
  assign lb = rdata[{off, 3'b000} +: 8];
  assign lh = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    wdata_lane = '0;
    wstrb      = '0;
    rdata_ext  = '0;
    unique case (1'b1)
      op == LB:  rdata_ext = {{24{lb[7]}}, lb};
      op == LBU: rdata_ext = {24'b0, lb};
      op == LH:  rdata_ext = {{16{lh[15]}}, lh};
      op == LHU: rdata_ext = {16'b0, lh};
      op == LW:  rdata_ext = rdata;
      op == SB: begin
        wstrb      = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
      end
      op == SH: begin
        wstrb      = 4'b0011 << {off[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
      end
      op == SW: begin
        wstrb      = 4'b1111;
        wdata_lane = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: multi-cycle load/store unit, one bus transaction per request.
// Ports: clock, reset (async, active-high); lsu_reqValid, req_op,
// req_addr, req_wdata in; lsu_respValid, resp_rdata, resp_err, busy
// out; mem (lsu_if.master) data-memory bus.
// Option: LSU_MISALIGN_CHK_EN enables misaligned-access error return.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lsu_reqValid,
  input  lsu_op_t           req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              lsu_respValid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  lsu_if.master             mem
);

  if (DATA_W != 32) begin : g_dw_chk
    $error("lsu: only DATA_W == 32 is supported");
  end

  lsu_state_t        state;
  lsu_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       wdata_lane;
  logic [3:0]        wstrb;
  logic [31:0]       rdata_ext;

  lsu_align u_align (
    .op         (op_q),
    .off        (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (mem.mem_rdata),
    .wdata_lane (wdata_lane),
    .wstrb      (wstrb),
    .rdata_ext  (rdata_ext)
  );

  assign busy          = (state != IDLE);
  assign lsu_respValid = (state == RESP);

  // bus fields come straight from the capture regs: stable in REQ
  assign mem.mem_req_valid = (state == REQ);
  assign mem.mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.mem_wen       = is_store(op_q);
  assign mem.mem_wdata     = wdata_lane;
  assign mem.mem_wstrb     = wstrb;

`ifdef LSU_MISALIGN_CHK_EN
  logic err_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= LB;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
`ifdef LSU_MISALIGN_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (lsu_reqValid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_CHK_EN
            if (is_misaligned(req_op, req_addr[1:0])) begin
              state      <= RESP;
              resp_rdata <= '0;
              err_q      <= 1'b1;
            end else begin
              state <= REQ;
              err_q <= 1'b0;
            end
`else
            state <= REQ;
`endif
          end
        end
        REQ: begin
          if (mem.mem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem.mem_resp_valid) begin
            state      <= RESP;
            // align returns 0 for stores
            resp_rdata <= rdata_ext;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu with a byte-level reference model.
// Directed cases first, then randomized ops, addresses and bus delays.
`timescale 1ns/1ps
module tb_lsu;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        lsu_reqValid = 1'b0;
  lsu_op_t     req_op = LB;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        lsu_respValid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  lsu_if #(.ADDR_W(32), .DATA_W(32)) m ();

  logic        auto_en = 1'b1;
  logic        a_ready = 1'b0;
  logic        a_resp = 1'b0;
  logic [31:0] a_rdata = '0;
  logic        man_ready = 1'b0;
  logic        man_resp = 1'b0;

  assign m.mem_req_ready  = auto_en ? a_ready : man_ready;
  assign m.mem_resp_valid = auto_en ? a_resp : man_resp;
  assign m.mem_rdata      = a_rdata;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .lsu_reqValid  (lsu_reqValid),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .lsu_respValid (lsu_respValid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .busy          (busy),
    .mem           (m)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          rdly;
    int          sdly;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(lsu_op_t op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      default:     return 4;
    endcase
  endfunction

  function automatic bit st(lsu_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic bit misal(lsu_op_t op, logic [31:0] a);
`ifdef LSU_MISALIGN_CHK_EN
    return (int'(a % 4) % nbytes(op)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // first byte lane of the access, rounded down to its natural size
  function automatic int base_lane(lsu_op_t op, logic [31:0] a);
    int o;
    o = int'(a % 4);
    return o - (o % nbytes(op));
  endfunction

  function automatic logic [31:0] ref_load(lsu_op_t op, logic [31:0] a,
                                           logic [31:0] w);
    int     n;
    int     b;
    longint v;
    n = nbytes(op);
    b = base_lane(op, a);
    v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(w[8*(b+i) +: 8]) << (8 * i);
    if ((op == LB || op == LH) && v[8*n-1])
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(lsu_op_t op, logic [31:0] a);
    logic [3:0] s;
    s = '0;
    if (st(op))
      for (int i = 0; i < nbytes(op); i++) s[base_lane(op, a) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(lsu_op_t op, logic [31:0] wd);
    logic [31:0] d;
    for (int k = 0; k < 4; k++) d[8*k +: 8] = wd[8*(k % nbytes(op)) +: 8];
    return d;
  endfunction

  // ---------------- stimulus ----------------
  task automatic issue(lsu_op_t op, logic [31:0] a, logic [31:0] wd,
                       logic [31:0] rd, int rdly, int sdly);
    bus_t b;
    rsp_t r;
    bit   got;
    got = 1'b0;
    @(negedge clock);
    if (misal(op, a)) begin
      r.rdata = '0;
      r.err   = 1'b1;
      r.cyc   = cyc + 1;
    end else begin
      b.addr  = a & 32'hFFFF_FFFC;
      b.wen   = st(op);
      b.wdata = ref_wdata(op, wd);
      b.wstrb = ref_strb(op, a);
      b.rdata = rd;
      b.rdly  = rdly;
      b.sdly  = sdly;
      bus_q.push_back(b);
      r.rdata = st(op) ? 32'h0 : ref_load(op, a, rd);
      r.err   = 1'b0;
      r.cyc   = cyc + 3 + rdly + sdly;
    end
    rsp_q.push_back(r);
    lsu_reqValid = 1'b1;
    req_op       = op;
    req_addr     = a;
    req_wdata    = wd;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clock);
      lsu_reqValid = 1'b0;
      req_op       = lsu_op_t'($urandom_range(0, 7));
      req_addr     = $urandom;
      req_wdata    = $urandom;
      got          = lsu_respValid;
    end
    if (!got) begin
      n_total++;
      $display("FAIL timeout op=%s addr=0x%08h: no lsu_respValid, want one",
               op.name(), a);
      rsp_q.delete();
      bus_q.delete();
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    bus_t b;
    forever begin
      @(negedge clock);
      if (auto_en && !reset && m.mem_req_valid) begin
        a_resp = 1'b0;
        if (bus_q.size() == 0) begin
          n_total++;
          $display("FAIL bus_unexpected: request addr=0x%08h, want none",
                   m.mem_addr);
          a_ready = 1'b1;
          @(negedge clock);
          a_ready = 1'b0;
        end else begin
          b = bus_q.pop_front();
          chk("mem_addr", m.mem_addr, b.addr);
          chk("mem_wen", 32'(m.mem_wen), 32'(b.wen));
          chk("mem_wstrb", 32'(m.mem_wstrb), 32'(b.wstrb));
          if (b.wen) chk("mem_wdata", m.mem_wdata, b.wdata);
          for (int i = 0; i < b.rdly; i++) begin
            @(negedge clock);
            chk("req_hold_valid", 32'(m.mem_req_valid), 32'd1);
            chk("req_hold_addr", m.mem_addr, b.addr);
            chk("req_hold_wstrb", 32'(m.mem_wstrb), 32'(b.wstrb));
          end
          a_ready = 1'b1;
          @(negedge clock);
          a_ready = 1'b0;
          repeat (b.sdly) @(negedge clock);
          a_resp  = 1'b1;
          a_rdata = b.rdata;
          @(negedge clock);
          a_resp  = 1'b0;
          a_rdata = $urandom;
        end
      end else begin
        // stray responses while idle must be ignored
        a_resp  = ($urandom_range(0, 3) == 0);
        a_rdata = $urandom;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : monitor
    rsp_t r;
    forever begin
      @(negedge clock);
      if (!reset && lsu_respValid) begin
        if (rsp_q.size() == 0) begin
          n_total++;
          $display("FAIL resp_unexpected: rdata=0x%08h, want no response",
                   resp_rdata);
        end else begin
          r = rsp_q.pop_front();
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", 32'(resp_err), 32'(r.err));
          chk("resp_cycle", cyc, r.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk_zero(string tag);
    chk({tag, "_ctl"}, 32'({lsu_respValid, resp_err, busy, m.mem_req_valid,
                            m.mem_wen, m.mem_wstrb}), 32'd0);
    chk({tag, "_addr"}, m.mem_addr, 32'd0);
    chk({tag, "_wdata"}, m.mem_wdata, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk_zero("rst");
    chk("rst_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk_zero("post_rst");

    issue(SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    issue(SB, 32'h103, 32'h000000A5, 32'h0, 0, 0);
    issue(LB, 32'h102, 32'h0, 32'h12F03456, 0, 0);
    issue(LBU, 32'h102, 32'h0, 32'h12F03456, 1, 2);
    issue(LH, 32'h102, 32'h0, 32'h80011234, 5, 0);
    issue(LHU, 32'h100, 32'h0, 32'h80011234, 0, 1);
    issue(SH, 32'h102, 32'h0000BEEF, 32'h0, 2, 0);
    issue(LW, 32'h102, 32'h0, 32'h11223344, 0, 0);
    issue(SW, 32'h101, 32'hCAFEF00D, 32'h0, 0, 0);
    issue(LH, 32'h103, 32'h0, 32'h7F00FF80, 0, 0);

    // reqValid held through a store, then reset while waiting
    auto_en   = 1'b0;
    man_ready = 1'b0;
    man_resp  = 1'b0;
    @(negedge clock);
    req_op       = SW;
    req_addr     = 32'h200;
    req_wdata    = $urandom;
    lsu_reqValid = 1'b1;
    @(negedge clock);
    chk("t5_req_valid", 32'(m.mem_req_valid), 32'd1);
    man_ready = 1'b1;
    @(negedge clock);
    man_ready = 1'b0;
    chk("t5_wait_noreq", 32'(m.mem_req_valid), 32'd0);
    @(negedge clock);
    chk("t5_wait_hold", 32'({busy, m.mem_req_valid}), 32'b10);
    reset        = 1'b1;
    lsu_reqValid = 1'b0;
    #1;
    chk_zero("t5_rst");
    @(negedge clock);
    reset    = 1'b0;
    man_resp = 1'b1;
    @(negedge clock);
    man_resp = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("t5_idle", 32'({lsu_respValid, busy, m.mem_req_valid}), 32'd0);
    end
    auto_en = 1'b1;

    for (int i = 0; i < 80; i++)
      issue(lsu_op_t'($urandom_range(0, 7)),
            32'h1000 + 32'($urandom_range(0, 255)),
            $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3));

    repeat (3) @(negedge clock);
    if (rsp_q.size() != 0 || bus_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d responses, %0d bus requests left, want 0",
               rsp_q.size(), bus_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
